uart_frame_parser: RTL and testbench

Byte-stream deframer placed directly downstream of the Arduino UART receive buffer. It consumes received bytes over a valid/ready handshake, hunts for a sync byte, and assembles `SYNC | CMD | LEN | PAYLOAD[LEN] | CHK` frames. It checks length and XOR checksum, then presents one complete command to the application logic (LED/control) on a valid/ready output. Malformed, oversize or stalled frames are dropped and reported through single-cycle error pulses.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_frame_parser.sv | 142 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command path: frame parser states and the sync marker.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } frame_state_t;

    localparam logic [7:0] UART_SYNC_BYTE = 8'h7E;

endpackage

// File: rtl/uart_frame_parser.sv
// Deframes SYNC|CMD|LEN|PAYLOAD|CHK byte streams from the UART RX buffer into held commands,
// dropping bad frames with one-cycle error pulses.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD    = 8,
    parameter logic [7:0]  SYNC_BYTE      = UART_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_cmd,
    output logic [3:0]               out_len,
    output logic [8*MAX_PAYLOAD-1:0] out_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_checksum,
    output logic                     err_length,
    output logic                     err_timeout
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    frame_state_t         state_q, state_d;
    logic [7:0]           xor_q;
    logic [3:0]           idx_q;
    logic [TIMER_W-1:0]   timer_q;
    logic                 accept;
    logic                 timer_active;
    logic                 timeout;
    logic                 err_checksum_d, err_length_d, err_timeout_d;

    assign in_ready     = rst_n && (state_q != HOLD);
    assign accept       = in_valid && in_ready;
    assign timer_active = (state_q == CMD) || (state_q == LEN) ||
                          (state_q == PAYLOAD) || (state_q == CHK);
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign timeout      = timer_active && !accept &&
                          (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d        = state_q;
        err_checksum_d = 1'b0;
        err_length_d   = 1'b0;
        err_timeout_d  = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept && in_data == SYNC_BYTE) state_d = CMD;
            end
            CMD: begin
                if (accept) state_d = LEN;
            end
            LEN: begin
                if (accept) begin
                    if (in_data > 8'(MAX_PAYLOAD)) begin
                        err_length_d = 1'b1;
                        state_d      = HUNT;
                    end else if (in_data == 8'h00) begin
                        state_d = CHK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept && idx_q == (out_len - 4'd1)) state_d = CHK;
            end
            CHK: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d = HOLD;
                    end else begin
                        err_checksum_d = 1'b1;
                        state_d        = HUNT;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
        if (timeout) begin
            err_timeout_d = 1'b1;
            state_d       = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            xor_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            out_cmd      <= '0;
            out_len      <= '0;
            out_payload  <= '0;
            out_valid    <= 1'b0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid    <= (state_d == HOLD);
            err_checksum <= err_checksum_d;
            err_length   <= err_length_d;
            err_timeout  <= err_timeout_d;
            if (accept || !timer_active || state_d == HUNT) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TIMER_W'(1);
            end
            if (accept) begin
                case (state_q)
                    CMD: begin
                        out_cmd     <= in_data;
                        xor_q       <= in_data;
                        out_payload <= '0;
                        idx_q       <= '0;
                    end
                    LEN: begin
                        xor_q <= xor_q ^ in_data;
                        // An oversize length is never exposed on out_len.
                        if (in_data <= 8'(MAX_PAYLOAD)) out_len <= in_data[3:0];
                    end
                    PAYLOAD: begin
                        for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                            if (idx_q == 4'(i)) out_payload[8*i +: 8] <= in_data;
                        end
                        xor_q <= xor_q ^ in_data;
                        idx_q <= idx_q + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: per-cycle vector table plus timeout, backpressure and reset sequences.
module tb_uart_frame_parser;

    localparam int MP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_cmd;
    logic [3:0]    out_len;
    logic [8*MP-1:0] out_payload;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          err_checksum, err_length, err_timeout;

    int n_vec  = 0;
    int n_miss = 0;

    uart_frame_parser #(
        .MAX_PAYLOAD   (MP),
        .SYNC_BYTE     (8'h7E),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_cmd     (out_cmd),
        .out_len     (out_len),
        .out_payload (out_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_checksum(err_checksum),
        .err_length  (err_length),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        o;
        logic [80:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [80:0] pk(input logic ir, input logic ov, input logic [7:0] cmd,
                                       input logic [3:0] len, input logic [63:0] pl,
                                       input logic [2:0] err);
        return {ir, ov, cmd, len, pl, err};
    endfunction

    function automatic logic [80:0] obs();
        return {in_ready, out_valid, out_cmd, out_len, out_payload,
                err_checksum, err_length, err_timeout};
    endfunction

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic o,
                       input logic [80:0] e);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.o = o; x.exp = e;
        tbl.push_back(x);
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic o);
        @(negedge clk);
        rst_n = r; in_valid = v; in_data = d; out_ready = o;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // err field order is {checksum, length, timeout}
    initial begin
        logic [63:0] pl;
        logic [80:0] e;
        int          cnt;
        int          first;

        // reset, then good frame 7E 01 02 10 20 33
        add(0, 0, 8'h00, 0, pk(0, 0, 8'h00, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h7E, 0, pk(1, 0, 8'h00, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h01, 0, pk(1, 0, 8'h01, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h02, 0, pk(1, 0, 8'h01, 4'd2, 64'h0, 3'b000));
        add(1, 1, 8'h10, 0, pk(1, 0, 8'h01, 4'd2, 64'h10, 3'b000));
        add(1, 1, 8'h20, 0, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));
        add(1, 1, 8'h33, 0, pk(0, 1, 8'h01, 4'd2, 64'h2010, 3'b000));
        add(1, 0, 8'h00, 1, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));
        // garbage then zero-length frame 7E 05 00 05
        add(1, 1, 8'h00, 0, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));
        add(1, 1, 8'hFF, 0, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));
        add(1, 1, 8'h7E, 0, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));
        add(1, 1, 8'h05, 0, pk(1, 0, 8'h05, 4'd2, 64'h0, 3'b000));
        add(1, 1, 8'h00, 0, pk(1, 0, 8'h05, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h05, 0, pk(0, 1, 8'h05, 4'd0, 64'h0, 3'b000));
        add(1, 0, 8'h00, 1, pk(1, 0, 8'h05, 4'd0, 64'h0, 3'b000));
        // bad checksum 7E 01 02 10 20 34
        add(1, 1, 8'h7E, 0, pk(1, 0, 8'h05, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h01, 0, pk(1, 0, 8'h01, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h02, 0, pk(1, 0, 8'h01, 4'd2, 64'h0, 3'b000));
        add(1, 1, 8'h10, 0, pk(1, 0, 8'h01, 4'd2, 64'h10, 3'b000));
        add(1, 1, 8'h20, 0, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));
        add(1, 1, 8'h34, 0, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b100));
        add(1, 0, 8'h00, 0, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));
        // oversize 7E 01 09, then 41 ignored
        add(1, 1, 8'h7E, 0, pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));
        add(1, 1, 8'h01, 0, pk(1, 0, 8'h01, 4'd2, 64'h0, 3'b000));
        add(1, 1, 8'h09, 0, pk(1, 0, 8'h01, 4'd2, 64'h0, 3'b010));
        add(1, 1, 8'h41, 0, pk(1, 0, 8'h01, 4'd2, 64'h0, 3'b000));
        // 7E 03 01 AA A8, SYNC offered during HOLD is not taken, then SYNC used as data
        add(1, 1, 8'h7E, 0, pk(1, 0, 8'h01, 4'd2, 64'h0, 3'b000));
        add(1, 1, 8'h03, 0, pk(1, 0, 8'h03, 4'd2, 64'h0, 3'b000));
        add(1, 1, 8'h01, 0, pk(1, 0, 8'h03, 4'd1, 64'h0, 3'b000));
        add(1, 1, 8'hAA, 0, pk(1, 0, 8'h03, 4'd1, 64'hAA, 3'b000));
        add(1, 1, 8'hA8, 0, pk(0, 1, 8'h03, 4'd1, 64'hAA, 3'b000));
        add(1, 1, 8'h7E, 1, pk(1, 0, 8'h03, 4'd1, 64'hAA, 3'b000));
        add(1, 1, 8'h7E, 0, pk(1, 0, 8'h03, 4'd1, 64'hAA, 3'b000));
        add(1, 1, 8'h7E, 0, pk(1, 0, 8'h7E, 4'd1, 64'h0, 3'b000));
        add(1, 1, 8'h00, 0, pk(1, 0, 8'h7E, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h7E, 0, pk(0, 1, 8'h7E, 4'd0, 64'h0, 3'b000));
        add(1, 0, 8'h00, 1, pk(1, 0, 8'h7E, 4'd0, 64'h0, 3'b000));
        // full-length frame 7E 11 08 01..08 11
        add(1, 1, 8'h7E, 0, pk(1, 0, 8'h7E, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h11, 0, pk(1, 0, 8'h11, 4'd0, 64'h0, 3'b000));
        add(1, 1, 8'h08, 0, pk(1, 0, 8'h11, 4'd8, 64'h0, 3'b000));
        pl = '0;
        for (int k = 1; k <= 8; k++) begin
            pl[8*(k-1) +: 8] = 8'(k);
            add(1, 1, 8'(k), 0, pk(1, 0, 8'h11, 4'd8, pl, 3'b000));
        end
        add(1, 1, 8'h11, 0, pk(0, 1, 8'h11, 4'd8, 64'h0807060504030201, 3'b000));
        add(1, 0, 8'h00, 1, pk(1, 0, 8'h11, 4'd8, 64'h0807060504030201, 3'b000));

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].o);
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // gap timeout: 100 idle cycles after 7E 01
        step(1, 1, 8'h7E, 0);
        step(1, 1, 8'h01, 0);
        cnt = 0; first = -1;
        for (int i = 1; i <= 120; i++) begin
            step(1, 0, 8'h00, 0);
            if (err_timeout) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk("timeout_pulses", 81'(cnt), 81'd1);
        chk("timeout_cycle", 81'(first), 81'd100);
        step(1, 1, 8'h7E, 0);
        step(1, 1, 8'h02, 0);
        step(1, 1, 8'h00, 0);
        step(1, 1, 8'h02, 0);
        chk("after_timeout_frame", obs(), pk(0, 1, 8'h02, 4'd0, 64'h0, 3'b000));
        step(1, 0, 8'h00, 1);

        // byte arriving in the expiry cycle beats the timeout
        step(1, 1, 8'h7E, 0);
        step(1, 1, 8'h01, 0);
        repeat (99) step(1, 0, 8'h00, 0);
        step(1, 1, 8'h00, 0);
        chk("byte_wins_timeout", obs(), pk(1, 0, 8'h01, 4'd0, 64'h0, 3'b000));
        step(1, 1, 8'h01, 0);
        chk("byte_wins_frame", obs(), pk(0, 1, 8'h01, 4'd0, 64'h0, 3'b000));
        step(1, 0, 8'h00, 1);

        // backpressure: hold 50 cycles with SYNC offered, then release
        step(1, 1, 8'h7E, 0);
        step(1, 1, 8'h01, 0);
        step(1, 1, 8'h02, 0);
        step(1, 1, 8'h10, 0);
        step(1, 1, 8'h20, 0);
        step(1, 1, 8'h33, 0);
        e = pk(0, 1, 8'h01, 4'd2, 64'h2010, 3'b000);
        for (int i = 0; i < 50; i++) begin
            step(1, 1, 8'h7E, 0);
            chk($sformatf("hold%0d", i), obs(), e);
        end
        step(1, 0, 8'h00, 1);
        chk("hold_release", obs(), pk(1, 0, 8'h01, 4'd2, 64'h2010, 3'b000));

        // reset mid-frame, trailing bytes must not complete anything
        step(1, 1, 8'h7E, 0);
        step(1, 1, 8'h01, 0);
        step(1, 1, 8'h02, 0);
        step(1, 1, 8'h10, 0);
        step(0, 0, 8'h00, 0);
        chk("mid_reset", obs(), pk(0, 0, 8'h00, 4'd0, 64'h0, 3'b000));
        step(1, 1, 8'h20, 0);
        chk("post_reset_20", obs(), pk(1, 0, 8'h00, 4'd0, 64'h0, 3'b000));
        step(1, 1, 8'h33, 0);
        chk("post_reset_33", obs(), pk(1, 0, 8'h00, 4'd0, 64'h0, 3'b000));
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 0);
            chk($sformatf("post_reset_idle%0d", i), obs(), pk(1, 0, 8'h00, 4'd0, 64'h0, 3'b000));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
